jkreg_scan_ctl: RTL and testbench

Sequencing controller for an N-bit scan-capable JK register bank in the datapath. It accepts one command at a time over a START/BUSY/DONE handshake and performs one of four operations: a single-cycle functional J/K update, a serial scan load, a serial scan unload, or a scan swap (load and unload together). It drives the bank's TEST, SCANIN, J and K inputs, and reassembles the serial SCANOUT stream into parallel RDATA.

---
 rtl/jkreg_scan_ctl.sv | 157 +++++++++++++++
 tb/tb_jkreg_scan_ctl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/jkreg_scan_ctl.sv
// Command sequencer for an N-bit scan-capable JK register bank: functional update, scan load/unload/swap.
// Optional JKSC_PARITY_EN builds a registered even-parity bit RPAR alongside RDATA.
module jkreg_scan_ctl #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic           CLK,
  input  logic           CLR,
  input  logic           START,
  input  logic [1:0]     OP,
  input  logic [N-1:0]   WDATA,
  input  logic [N-1:0]   KMASK,
  input  logic           SCANOUT,
  output logic           BUSY,
  output logic           DONE,
  output logic           ERR,
  output logic [N-1:0]   RDATA,
  output logic           RPAR,
  output logic           TEST,
  output logic           SCANIN,
  output logic [N-1:0]   J,
  output logic [N-1:0]   K,
  output logic [1:0]     dbg_state
);

  // Handshake: START is sampled only in IDLE; BUSY covers FUNC/SHIFT/FIN,
  // DONE pulses in FIN, and START seen while BUSY yields a one-cycle ERR.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FUNC  = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [N-2:0]     ld_sh_q, ld_sh_d;
  logic [N-1:0]     rdata_sh_q, rdata_sh_d;
  logic [N-1:0]     rdata_q, rdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             test_q, test_d;
  logic             scanin_q, scanin_d;
  logic [N-1:0]     j_q, j_d;
  logic [N-1:0]     k_q, k_d;
  logic             last_shift;
  logic [N-1:0]     sh_next;

  assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(N - 1));
  assign sh_next    = {rdata_sh_q[N-2:0], SCANOUT};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    ld_sh_d    = ld_sh_q;
    rdata_sh_d = rdata_sh_q;
    rdata_d    = rdata_q;
    test_d     = 1'b0;
    scanin_d   = 1'b0;
    j_d        = '0;
    k_d        = '0;
    err_d      = START && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (START) begin
          op_d    = OP;
          cnt_d   = '0;
          ld_sh_d = WDATA[N-2:0];
          if (OP == 2'b00) begin
            state_d = FUNC;
            j_d     = WDATA;
            k_d     = KMASK;
          end else begin
            // Outputs are registered, so the first serial bit is set up here.
            state_d  = SHIFT;
            test_d   = 1'b1;
            scanin_d = OP[0] & WDATA[N-1];
          end
        end
      end
      FUNC: state_d = FIN;
      SHIFT: begin
        if (op_q[1]) rdata_sh_d = sh_next;
        if (last_shift) begin
          state_d = FIN;
          if (op_q[1]) rdata_d = sh_next;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          test_d   = 1'b1;
          scanin_d = op_q[0] & ld_sh_q[N-2];
          ld_sh_d  = ld_sh_q << 1;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      ld_sh_q    <= '0;
      rdata_sh_q <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      test_q     <= 1'b0;
      scanin_q   <= 1'b0;
      j_q        <= '0;
      k_q        <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      ld_sh_q    <= ld_sh_d;
      rdata_sh_q <= rdata_sh_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      test_q     <= test_d;
      scanin_q   <= scanin_d;
      j_q        <= j_d;
      k_q        <= k_d;
    end
  end

`ifdef JKSC_PARITY_EN
  logic rpar_q;
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)                     rpar_q <= 1'b0;
    else if (last_shift && op_q[1]) rpar_q <= ^sh_next;
  end
  assign RPAR = rpar_q;
`else
  assign RPAR = 1'b0;
`endif

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign RDATA     = rdata_q;
  assign TEST      = test_q;
  assign SCANIN    = scanin_q;
  assign J         = j_q;
  assign K         = k_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_jkreg_scan_ctl.sv
// Bench for jkreg_scan_ctl: behavioural JK scan bank, directed commands, DONE-driven scoreboard.
module tb_jkreg_scan_ctl;
  localparam int N     = 8;
  localparam int CNT_W = 4;
  localparam int W     = 2 * N + 9;

  logic         CLK = 1'b0;
  logic         CLR = 1'b0;
  logic         START = 1'b0;
  logic [1:0]   OP = 2'b00;
  logic [N-1:0] WDATA = '0;
  logic [N-1:0] KMASK = '0;
  logic         SCANOUT;
  logic         BUSY, DONE, ERR, RPAR, TEST, SCANIN;
  logic [N-1:0] RDATA, J, K;
  logic [1:0]   dbg_state;

  jkreg_scan_ctl #(.N(N), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .CLR(CLR), .START(START), .OP(OP), .WDATA(WDATA), .KMASK(KMASK),
    .SCANOUT(SCANOUT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA), .RPAR(RPAR),
    .TEST(TEST), .SCANIN(SCANIN), .J(J), .K(K), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // behavioural register bank
  logic [N-1:0] bank_q = '0;
  logic         pre_en = 1'b0;
  logic [N-1:0] pre_v = '0;
  assign SCANOUT = bank_q[N-1];
  always @(posedge CLK) begin
    if (pre_en) bank_q <= pre_v;
    else if (TEST) bank_q <= {bank_q[N-2:0], SCANIN};
    else begin
      for (int i = 0; i < N; i++) begin
        case ({J[i], K[i]})
          2'b10:   bank_q[i] <= 1'b1;
          2'b01:   bank_q[i] <= 1'b0;
          2'b11:   bank_q[i] <= ~bank_q[i];
          default: bank_q[i] <= bank_q[i];
        endcase
      end
    end
  end

  // free-running observers, sampled mid-cycle
  int           test_cyc = 0, jk_cyc = 0, err_cyc = 0;
  logic [N-1:0] scan_bits = '0, last_j = '0, last_k = '0;
  always @(negedge CLK) begin
    if (TEST) begin
      test_cyc  <= test_cyc + 1;
      scan_bits <= {scan_bits[N-2:0], SCANIN};
    end
    if ((J != '0) || (K != '0)) begin
      jk_cyc <= jk_cyc + 1;
      last_j <= J;
      last_k <= K;
    end
    if (ERR) err_cyc <= err_cyc + 1;
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0, n_errs = 0;
  int acc_cyc = 0;
  logic [N-1:0] rdata_m = '0;
  logic         rpar_m = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic par_of(input logic [N-1:0] v);
`ifdef JKSC_PARITY_EN
    return ^v;
`else
    return 1'b0;
`endif
  endfunction

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge CLK);
      if (CLR && DONE) begin
        if (exp_q.size() == 0) check("unexpected_done", 32'(DONE), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("rdata", 32'(RDATA), 32'(e[2*N+8:N+9]));
          check("rpar", 32'(RPAR), 32'(e[N+8]));
          check("bank_q", 32'(bank_q), 32'(e[N+7:8]));
          check("done_latency", 32'(cyc - acc_cyc), 32'(e[7:0]));
          check("busy_at_done", 32'(BUSY), 32'd1);
        end
      end
    end
  end

  task automatic preload(input logic [N-1:0] v);
    pre_v = v; pre_en = 1'b1;
    @(posedge CLK); #1;
    pre_en = 1'b0;
  endtask

  // Issue one command; inj_cyc>0 strobes START in that SHIFT cycle, inj_done strobes it in the DONE cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [N-1:0] pre, input logic [N-1:0] wdata,
                         input logic [N-1:0] kmask, input logic [N-1:0] exp_bank,
                         input logic [N-1:0] exp_unload, input int inj_cyc, input bit inj_done);
    int t0, j0, e0, lat;
    bit seen;
    preload(pre);
    if (op[1]) begin
      rdata_m = exp_unload;
      rpar_m  = par_of(exp_unload);
    end
    lat = (op == 2'b00) ? 1 : N;
    exp_q.push_back({rdata_m, rpar_m, exp_bank, 8'(lat)});
    t0 = test_cyc; j0 = jk_cyc; e0 = err_cyc;
    START = 1'b1; OP = op; WDATA = wdata; KMASK = kmask;
    @(posedge CLK); #1;
    acc_cyc = cyc;
    START = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 * N; i++) begin
      @(posedge CLK); #1;
      START = 1'b0;
      if (inj_cyc != 0 && i == inj_cyc - 2) begin
        START = 1'b1; OP = 2'b00; WDATA = ~wdata; KMASK = ~kmask;
      end
      if (DONE) begin
        seen = 1'b1;
        if (inj_done) begin
          START = 1'b1; OP = 2'b01; WDATA = ~wdata;
        end
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    if (inj_done) begin
      @(posedge CLK); #1;
      START = 1'b0;
    end
    repeat (3) begin @(posedge CLK); #1; end
    check("test_cycles", 32'(test_cyc - t0), (op == 2'b00) ? 32'd0 : 32'(N));
    check("jk_cycles", 32'(jk_cyc - j0), (op == 2'b00) ? 32'd1 : 32'd0);
    check("err_cycles", 32'(err_cyc - e0), 32'(int'(inj_cyc != 0) + int'(inj_done)));
    if (op == 2'b00) begin
      check("j_value", 32'(last_j), 32'(wdata));
      check("k_value", 32'(last_k), 32'(kmask));
    end else begin
      check("scanin_seq", 32'(scan_bits), op[0] ? 32'(wdata) : 32'd0);
    end
    check("idle_busy", 32'(BUSY), 32'd0);
    check("idle_state", 32'(dbg_state), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    // reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_test", 32'(TEST), 32'd0);
    check("rst_scanin", 32'(SCANIN), 32'd0);
    check("rst_jk", 32'({J, K}), 32'd0);
    check("rst_rdata", 32'(RDATA), 32'd0);
    check("rst_rpar", 32'(RPAR), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    CLR = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end

    //      op     pre    wdata  kmask  exp_bank exp_unload inj done
    run_cmd(2'b01, 8'h00, 8'hA5, 8'h00, 8'hA5,   8'h00,     0,  0); // load
    run_cmd(2'b10, 8'h3C, 8'h00, 8'h00, 8'h00,   8'h3C,     0,  0); // unload
    run_cmd(2'b11, 8'h81, 8'h7E, 8'h00, 8'h7E,   8'h81,     0,  0); // swap
    run_cmd(2'b00, 8'hF0, 8'h0F, 8'h30, 8'hCF,   8'h00,     0,  0); // functional
    run_cmd(2'b00, 8'h55, 8'hFF, 8'hFF, 8'hAA,   8'h00,     0,  0); // toggle all
    run_cmd(2'b11, 8'h5A, 8'hC3, 8'h00, 8'hC3,   8'h5A,     3,  0); // START in SHIFT cycle 3
    run_cmd(2'b10, 8'h07, 8'h00, 8'h00, 8'h00,   8'h07,     0,  1); // START in DONE cycle

    // reset in SHIFT cycle 4
    preload(8'h00);
    START = 1'b1; OP = 2'b01; WDATA = 8'h3C;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    CLR = 1'b0;
    #1;
    check("midrst_test", 32'(TEST), 32'd0);
    check("midrst_busy", 32'(BUSY), 32'd0);
    check("midrst_done", 32'(DONE), 32'd0);
    check("midrst_rdata", 32'(RDATA), 32'd0);
    check("midrst_rpar", 32'(RPAR), 32'd0);
    rdata_m = '0;
    rpar_m  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    CLR = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end
    run_cmd(2'b01, 8'h00, 8'hFF, 8'h00, 8'hFF,   8'h00,     0,  0); // load after reset

    repeat (3) begin @(posedge CLK); #1; end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
